fp_accum_seq: RTL
=================

FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the operand counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid  input  1, in_data  input  32, in_last  input  1  operand stream; in_last marks the final operand.
REQ-005 SHALL have port in_ready  output  1  operand accepted when in_valid & in_ready at an edge.
REQ-006 SHALL have ports adder_load  output  1, adder_num1  output  32, adder_num2  output  32  request to the downstream FP adder.
REQ-007 SHALL have ports adder_result  input  32, adder_result_ready  input  1  adder response.
REQ-008 SHALL have port adder_result_ack  output  1  adder response acknowledge.
REQ-009 SHALL have ports sum_valid  output  1, sum_data  output  32, sum_count  output  CNT_W  accumulated sum and operand count.
REQ-010 SHALL have port sum_ack  input  1  consumer acknowledge.

Function
REQ-011 SHALL implement states IDLE, NEXT, LOAD, WAIT, ACK, DONE; all outputs registered.
REQ-012 IDLE: in_ready=1; on accept, acc<=in_data, count<=1; go to DONE if in_last, else NEXT.
REQ-013 NEXT: in_ready=1; on accept, adder_num1<=acc, adder_num2<=in_data, last_q<=in_last, count<=count+1 saturating at 2^CNT_W-1; go to LOAD.
REQ-014 LOAD: adder_load=1 for exactly one cycle; go to WAIT.
REQ-015 WAIT: wait unbounded for adder_result_ready=1; on that edge acc<=adder_result; go to ACK.
REQ-016 ACK: adder_result_ack=1 for exactly one cycle; go to DONE if last_q, else NEXT.
REQ-017 adder_num1/adder_num2 SHALL remain stable from LOAD through ACK.
REQ-018 DONE: sum_valid=1, sum_data=acc, sum_count=count held stable until sum_ack=1; then IDLE, sum_valid low next cycle.
REQ-019 in_ready SHALL be 0 in LOAD, WAIT, ACK, DONE; at most one adder transaction in flight.
REQ-020 Single-operand stream (in_last on first operand) SHALL produce sum_data=operand, sum_count=1, no adder_load pulse.
REQ-021 sum_ack outside DONE and adder_result_ready outside WAIT SHALL be ignored.
REQ-022 Operands SHALL be passed bit-exact; no FP arithmetic inside this block.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, acc=0, count=0, last_q=0, adder_num1/2=0, adder_load=0, adder_result_ack=0, sum_valid=0, sum_data=0, sum_count=0, in_ready=0 during reset, in_ready=1 first cycle after release.
REQ-024 Reset mid-transaction (LOAD/WAIT/ACK) SHALL abandon it without ack; integration resets the adder simultaneously (adder reset driven by ~reset).

Structure
REQ-025 State encoding and FP constants (FP_ZERO=32'h0, FP_ONE=32'h3F800000) SHALL live in shared package fp_pkg.
REQ-026 SHALL be a single module; no sub-modules; top-level integration instantiates fp_accum_seq beside adder.

Verification
REQ-027 Single operand 32'h40490FDB with in_last -> sum_data=32'h40490FDB, sum_count=1, zero adder_load pulses.
REQ-028 Operands 1.0 (3F800000), 2.0 (40000000, last), behavioural adder latency 3 -> one load pulse with num1=3F800000, num2=40000000; sum_data=40400000, sum_count=2.
REQ-029 Four operands 1.0,1.0,1.0,1.0, adder latency randomised 1-8 -> three load pulses, each followed by one ack pulse; sum_data=40800000, sum_count=4.
REQ-030 sum_ack held low 10 cycles in DONE -> sum_valid, sum_data, sum_count stable, in_ready=0 throughout; one cycle after sum_ack, in_ready=1.
REQ-031 reset asserted in WAIT -> next cycle all outputs at reset values; new stream 2.0 (last) then yields sum_data=40000000, sum_count=1.
REQ-032 CNT_W=2, six operands of 0.0 -> sum_count saturates at 3, sum_data=0.

Source files
------------

// File: rtl/fp_accum_seq_pkg.sv
// rtl/fp_accum_seq_pkg.sv - shared FSM state encoding and FP constants for fp_accum_seq
//
// Package fp_pkg
//   state_t          : accumulator FSM states
//   FP_ZERO, FP_ONE  : IEEE-754 single-precision constants
//   accepts_operand  : true in the states that take an operand from the stream
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEXT,
        ST_LOAD,
        ST_WAIT,
        ST_ACK,
        ST_DONE
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    function automatic logic accepts_operand(input state_t s);
        return (s == ST_IDLE) || (s == ST_NEXT);
    endfunction

endpackage

// File: rtl/fp_accum_seq_if.sv
// rtl/fp_accum_seq_if.sv - operand stream, FP adder request/response and sum result bundle
//
// Interface fp_accum_seq_if #(CNT_W)
//   operand stream : in_valid, in_data[31:0], in_last, in_ready
//   adder request  : adder_load, adder_num1[31:0], adder_num2[31:0]
//   adder response : adder_result[31:0], adder_result_ready, adder_result_ack
//   sum result     : sum_valid, sum_data[31:0], sum_count[CNT_W-1:0], sum_ack
// Modports
//   master : environment side (drives stream, adder response, sum_ack)
//   slave  : fp_accum_seq side
interface fp_accum_seq_if #(
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_ready;

    logic             adder_load;
    logic [31:0]      adder_num1;
    logic [31:0]      adder_num2;
    logic [31:0]      adder_result;
    logic             adder_result_ready;
    logic             adder_result_ack;

    logic             sum_valid;
    logic [31:0]      sum_data;
    logic [CNT_W-1:0] sum_count;
    logic             sum_ack;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  adder_load, adder_num1, adder_num2,
        output adder_result, adder_result_ready,
        input  adder_result_ack,
        input  sum_valid, sum_data, sum_count,
        output sum_ack
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output adder_load, adder_num1, adder_num2,
        input  adder_result, adder_result_ready,
        output adder_result_ack,
        output sum_valid, sum_data, sum_count,
        input  sum_ack
    );

endinterface

// File: rtl/fp_accum_seq.sv
// rtl/fp_accum_seq.sv - sequential FP accumulator driving an external FP adder
//
// Module fp_accum_seq #(CNT_W = 8)
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : fp_accum_seq_if.slave (operand stream in, adder request/response, sum out)
// Operands are passed to the adder bit-exact; all arithmetic happens in the adder.
// One adder transaction at most is in flight. All outputs are registered and are
// decoded from the next state so they line up with the state they belong to.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    fp_accum_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [31:0]      acc, acc_n;
    logic [CNT_W-1:0] count, count_n;
    logic             last_q, last_n;
    logic [31:0]      num1_q, num1_n;
    logic [31:0]      num2_q, num2_n;

    logic             in_ready_q;
    logic             adder_load_q;
    logic             adder_ack_q;
    logic             sum_valid_q;
    logic [31:0]      sum_data_q;
    logic [CNT_W-1:0] sum_count_q;

    logic             accept;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        last_n  = last_q;
        num1_n  = num1_q;
        num2_n  = num2_q;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    acc_n   = bus.in_data;
                    count_n = CNT_ONE;
                    state_n = bus.in_last ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (accept) begin
                    num1_n  = acc;
                    num2_n  = bus.in_data;
                    last_n  = bus.in_last;
                    count_n = (count == CNT_MAX) ? count : count + 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: state_n = ST_WAIT;
            ST_WAIT: begin
                if (bus.adder_result_ready) begin
                    acc_n   = bus.adder_result;
                    state_n = ST_ACK;
                end
            end
            ST_ACK:  state_n = last_q ? ST_DONE : ST_NEXT;
            ST_DONE: begin
                if (bus.sum_ack) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            acc          <= FP_ZERO;
            count        <= '0;
            last_q       <= 1'b0;
            num1_q       <= FP_ZERO;
            num2_q       <= FP_ZERO;
            in_ready_q   <= 1'b0;
            adder_load_q <= 1'b0;
            adder_ack_q  <= 1'b0;
            sum_valid_q  <= 1'b0;
            sum_data_q   <= FP_ZERO;
            sum_count_q  <= '0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            count        <= count_n;
            last_q       <= last_n;
            num1_q       <= num1_n;
            num2_q       <= num2_n;
            in_ready_q   <= accepts_operand(state_n);
            adder_load_q <= (state_n == ST_LOAD);
            adder_ack_q  <= (state_n == ST_ACK);
            sum_valid_q  <= (state_n == ST_DONE);
            // The result is captured on entry to DONE and held until the next one.
            if (state_n == ST_DONE) begin
                sum_data_q  <= acc_n;
                sum_count_q <= count_n;
            end
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.adder_load       = adder_load_q;
    assign bus.adder_num1       = num1_q;
    assign bus.adder_num2       = num2_q;
    assign bus.adder_result_ack = adder_ack_q;
    assign bus.sum_valid        = sum_valid_q;
    assign bus.sum_data         = sum_data_q;
    assign bus.sum_count        = sum_count_q;

endmodule
